pattern_gen: RTL and testbench
==============================

// Module: pattern_gen
// PURPOSE
//  Multi-pixel-per-clock video test-pattern generator. Takes an upstream timing
//  stream (VS/HS/DE) and re-emits it with synthetic RGB pixel data.
//  Emits C_PORT_NUM pixels per clock, one per lane. Sits between a timing
//  generator and the frame-buffer write path as a known-data source.
// PARAMETERS
//  C_PORT_NUM  4  pixels (lanes) per clock; >=1
// PORTS
//  CLK_I  in   1               pixel-beat clock
//  RST_I  in   1               reset; asynchronous, active-high
//  VS_I   in   1               vertical sync, active-high
//  HS_I   in   1               horizontal sync, active-high
//  DE_I   in   1               data enable, active-high
//  VS_O   out  C_PORT_NUM      VS_I replicated on every lane, 1-clk delayed
//  HS_O   out  C_PORT_NUM      HS_I replicated on every lane, 1-clk delayed
//  DE_O   out  C_PORT_NUM      DE_I replicated on every lane, 1-clk delayed
//  R_O    out  C_PORT_NUM*8    red, lane p at bits [p*8+7:p*8]
//  G_O    out  C_PORT_NUM*8    green, same packing
//  B_O    out  C_PORT_NUM*8    blue, same packing
// BEHAVIOUR
//  - Single clock domain, all state on CLK_I rising edge.
//  - Reset is async active-high. While RST_I=1:
//    - all outputs are 0;
//    - hcnt, line, frame and the edge-detect registers are cleared.
//  - Latency: every output is registered with exactly 1 clk from the inputs.
//    VS_O/HS_O/DE_O lane p at cycle t+1 equal VS_I/HS_I/DE_I at cycle t.
//  - Edge detect uses a registered copy of the previous-cycle VS_I and DE_I.
//  - frame (8b): increments on each VS_I rising edge; wraps 255->0.
//  - line (16b):
//    - cleared on a VS_I rising edge;
//    - otherwise increments on each DE_I falling edge, i.e. one completed
//      active line;
//    - saturates at 0xFFFF.
//    - On a simultaneous VS rise and DE fall, the clear wins.
//  - hcnt (16b): beat counter within the active line.
//    - forced 0 while DE_I=0;
//    - increments each cycle with DE_I=1, saturating.
//    - The beat at DE_I rise uses hcnt=0.
//  - Pixel x index for lane p = hcnt*C_PORT_NUM + p. Compute in 16b, truncating.
//  - Colour for lane p when sampled DE_I=1:
//    - R = x[7:0]
//    - G = line[7:0]
//    - B = frame[7:0]
//  - When sampled DE_I=0, the R/G/B of all lanes are registered to 0.
//  - HS_I is passed through only; it does not affect the counters.
//  - Blanking without DE changes no counters except frame and line on VS.
//  - Reset mid-line: outputs go to 0 immediately (async). After release:
//    - counting resumes from 0;
//    - the first DE beat after release gives x=p and line=0.
// TESTING
//  1 Reset: hold RST_I=1 200ns, drive toggling VS/DE -> all outputs 0.
//    After release, outputs follow inputs by exactly 1 clk.
//  2 VS rise then DE high 100 beats, C_PORT_NUM=4 -> DE_O=4'hF for 100 cycles.
//    Beat0: R lanes = 00,01,02,03. Last beat: R = 0x8C..0x8F. G=0, B=1.
//  3 DE falls, HS pulse, DE high again 100 beats -> G=1 on all lanes.
//    R restarts at 00,01,02,03. B stays 1.
//  4 Beat 64 of a line -> x=256..259, R wraps to 00..03.
//  5 256 VS pulses -> B wraps to 0. A VS rise clears line: next line has G=0.
//  6 DE low cycles and sync pulses -> R/G/B=0. VS_O/HS_O equal the input
//    delayed 1 clk on all 4 lanes.

Source files
------------

// File: rtl/pattern_gen.sv
// Multi-lane video test-pattern generator: re-emits an upstream VS/HS/DE timing
// stream one clock later with synthetic RGB (R = pixel x, G = line, B = frame).
module pattern_gen #(
  parameter int unsigned C_PORT_NUM = 4
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    VS_I,
  input  logic                    HS_I,
  input  logic                    DE_I,
  output logic [C_PORT_NUM-1:0]   VS_O,
  output logic [C_PORT_NUM-1:0]   HS_O,
  output logic [C_PORT_NUM-1:0]   DE_O,
  output logic [C_PORT_NUM*8-1:0] R_O,
  output logic [C_PORT_NUM*8-1:0] G_O,
  output logic [C_PORT_NUM*8-1:0] B_O
);

  logic                    vs_prev_q, vs_prev_d;
  logic                    de_prev_q, de_prev_d;
  logic [7:0]              frame_q, frame_d;
  logic [15:0]             line_q, line_d;
  logic [15:0]             hcnt_q, hcnt_d;
  logic [C_PORT_NUM-1:0]   vs_q, vs_d;
  logic [C_PORT_NUM-1:0]   hs_q, hs_d;
  logic [C_PORT_NUM-1:0]   de_q, de_d;
  logic [C_PORT_NUM*8-1:0] r_q, r_d;
  logic [C_PORT_NUM*8-1:0] g_q, g_d;
  logic [C_PORT_NUM*8-1:0] b_q, b_d;

  logic       vs_rise;
  logic       de_fall;
  logic [7:0] x_lo;

  // Edge detection and frame/line/beat counter next-state.
  always_comb begin
    vs_rise   = VS_I & ~vs_prev_q;
    de_fall   = ~DE_I & de_prev_q;
    vs_prev_d = VS_I;
    de_prev_d = DE_I;

    frame_d = vs_rise ? frame_q + 8'd1 : frame_q;

    // A VS rise clears the line count even if a line completes in the same cycle.
    line_d = line_q;
    if (vs_rise) begin
      line_d = '0;
    end else if (de_fall && (line_q != 16'hFFFF)) begin
      line_d = line_q + 16'd1;
    end

    hcnt_d = '0;
    if (DE_I) begin
      hcnt_d = (hcnt_q != 16'hFFFF) ? hcnt_q + 16'd1 : hcnt_q;
    end
  end

  // Output next-state: sync replication and per-lane colour from current counters.
  always_comb begin
    vs_d = {C_PORT_NUM{VS_I}};
    hs_d = {C_PORT_NUM{HS_I}};
    de_d = {C_PORT_NUM{DE_I}};
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    x_lo = '0;
    if (DE_I) begin
      for (int p = 0; p < int'(C_PORT_NUM); p++) begin
        // Only the low byte of x = hcnt*C_PORT_NUM + p is visible, so compute it mod 256.
        x_lo          = hcnt_q[7:0] * 8'(C_PORT_NUM) + 8'(p);
        r_d[p*8 +: 8] = x_lo;
        g_d[p*8 +: 8] = line_q[7:0];
        b_d[p*8 +: 8] = frame_q;
      end
    end
  end

  // State and output registers; async reset clears everything immediately.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      frame_q   <= '0;
      line_q    <= '0;
      hcnt_q    <= '0;
      vs_q      <= '0;
      hs_q      <= '0;
      de_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      frame_q   <= frame_d;
      line_q    <= line_d;
      hcnt_q    <= hcnt_d;
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      de_q      <= de_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign VS_O = vs_q;
  assign HS_O = hs_q;
  assign DE_O = de_q;
  assign R_O  = r_q;
  assign G_O  = g_q;
  assign B_O  = b_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus randomized video-like timing,
// checked against an event-counting reference model.
module tb_pattern_gen;

  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         vs, hs, de;
  logic [C-1:0] vs_o, hs_o, de_o;
  logic [C*8-1:0] r_o, g_o, b_o;

  pattern_gen #(.C_PORT_NUM(C)) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .VS_I (vs),
    .HS_I (hs),
    .DE_I (de),
    .VS_O (vs_o),
    .HS_O (hs_o),
    .DE_O (de_o),
    .R_O  (r_o),
    .G_O  (g_o),
    .B_O  (b_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: counts events rather than mirroring registers.
  int vs_rises;     // VS rising edges since reset
  int lines_done;   // completed DE runs since last VS rise
  int beats_run;    // DE beats already seen in the current active run
  bit m_vs_prev, m_de_prev;

  task automatic model_reset();
    vs_rises   = 0;
    lines_done = 0;
    beats_run  = 0;
    m_vs_prev  = 1'b0;
    m_de_prev  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vs"}, 32'(vs_o), 32'h0);
    check({tag, "_hs"}, 32'(hs_o), 32'h0);
    check({tag, "_de"}, 32'(de_o), 32'h0);
    check({tag, "_r"}, r_o, 32'h0);
    check({tag, "_g"}, g_o, 32'h0);
    check({tag, "_b"}, b_o, 32'h0);
  endtask

  // One beat: drive inputs, predict, check one clock later, advance the model.
  task automatic step(input bit v, input bit h, input bit d);
    logic [31:0] er, eg, eb;
    bit vrise, dfall;
    @(negedge clk);
    vs = v; hs = h; de = d;
    vrise = v && !m_vs_prev;
    dfall = !d && m_de_prev;
    er = '0; eg = '0; eb = '0;
    if (d) begin
      for (int p = 0; p < int'(C); p++) begin
        er[p*8 +: 8] = 8'((beats_run * int'(C) + p) % 65536);
        eg[p*8 +: 8] = 8'(lines_done % 256);
        eb[p*8 +: 8] = 8'(vs_rises % 256);
      end
    end
    @(posedge clk);
    #1;
    check("vs_o", 32'(vs_o), v ? 32'hF : 32'h0);
    check("hs_o", 32'(hs_o), h ? 32'hF : 32'h0);
    check("de_o", 32'(de_o), d ? 32'hF : 32'h0);
    check("r_o", r_o, er);
    check("g_o", g_o, eg);
    check("b_o", b_o, eb);
    if (vrise) vs_rises++;
    if (vrise) lines_done = 0;
    else if (dfall && lines_done < 65535) lines_done++;
    beats_run = d ? ((beats_run < 65535) ? beats_run + 1 : beats_run) : 0;
    m_vs_prev = v;
    m_de_prev = d;
  endtask

  task automatic active_line(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int nblank, nde;
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0;
    model_reset();

    // Reset held 200 ns with toggling inputs: outputs stay 0.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vs = i[0]; de = i[1]; hs = i[2];
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0;
    model_reset();

    // Follow-by-one-clock with no VS rise yet.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // VS rise then 100-beat line: R 00..03 first, 8C..8F last, G=0, B=1.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("l0_beat0_r", r_o, 32'h03020100);
    check("l0_beat0_g", g_o, 32'h00000000);
    check("l0_beat0_b", b_o, 32'h01010101);
    active_line(63);
    step(1'b0, 1'b0, 1'b1);
    check("l0_beat64_r", r_o, 32'h03020100);
    active_line(34);
    step(1'b0, 1'b0, 1'b1);
    check("l0_beat99_r", r_o, 32'h8F8E8D8C);
    check("l0_beat99_de", 32'(de_o), 32'hF);

    // DE falls, HS pulse, second line: G=1, R restarts, B stays 1.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("l1_beat0_r", r_o, 32'h03020100);
    check("l1_beat0_g", g_o, 32'h01010101);
    check("l1_beat0_b", b_o, 32'h01010101);
    active_line(99);

    // 255 more VS pulses (256 total): frame wraps to 0, line cleared.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    check("wrap_b", b_o, 32'h00000000);
    check("wrap_g", g_o, 32'h00000000);
    active_line(9);
    step(1'b0, 1'b0, 1'b0);
    active_line(5);

    // VS rise coincident with DE fall: clear wins, next line G=0.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("vsclr_g", g_o, 32'h00000000);
    check("vsclr_b", b_o, 32'h01010101);
    active_line(7);

    // Randomized frames: blanking with HS/VS pulses, active runs of random length.
    for (int ln = 0; ln < 60; ln++) begin
      nblank = int'($urandom_range(1, 8));
      for (int i = 0; i < nblank; i++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
      end
      nde = int'($urandom_range(1, 90));
      for (int i = 0; i < nde; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset mid-line: outputs clear asynchronously, counting restarts.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    active_line(30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b1);
    check("post_rst_r", r_o, 32'h03020100);
    check("post_rst_g", g_o, 32'h00000000);
    check("post_rst_b", b_o, 32'h00000000);
    active_line(20);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("post_rst_l1_g", g_o, 32'h01010101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
